ls_mem_cntl_responder: RTL and testbench

Memory-controller end of the load/store-to-memory-controller channel in the PE. It accepts load and store requests from the PE load/store unit, applies them to a local single-port word memory, and returns load data in request order through a credit-protected response FIFO. Loads stall only when response space runs out. Stores complete without a response.

---
 rtl/ls_mem_cntl_responder.sv | 124 ++++++++++++
 tb/tb_ls_mem_cntl_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ls_mem_cntl_responder.sv
// Memory-controller end of the load/store channel: a single-port word memory
// serving in-order loads through a credit-protected, show-ahead response FIFO.
module ls_mem_cntl_responder #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 3072,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_poweron,
    input  logic                ls2mc_req_valid,
    output logic                ls2mc_req_ready,
    input  logic                ls2mc_req_store,
    input  logic [ADDR_W-1:0]   ls2mc_req_addr,
    input  logic [DATA_W-1:0]   ls2mc_req_wdata,
    input  logic [DATA_W/8-1:0] ls2mc_req_be,
    input  logic [TAG_W-1:0]    ls2mc_req_tag,
    output logic                mc2ls_rsp_valid,
    input  logic                mc2ls_rsp_ready,
    output logic [DATA_W-1:0]   mc2ls_rsp_data,
    output logic [TAG_W-1:0]    mc2ls_rsp_tag,
    output logic                mc2ls_rsp_err,
    output logic                busy,
    output logic [7:0]          err_count
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam logic [ADDR_W:0]  MEM_LIMIT    = (ADDR_W + 1)'(MEM_WORDS);
    localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(RSP_DEPTH);

    // Handshakes: a transfer happens at a rising edge where valid and ready are
    // both 1; valid never waits on ready, and payload is held while valid & !ready.

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [CNT_W-1:0]  credits;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_err;

    logic [DATA_W-1:0] fifo_data [RSP_DEPTH];
    logic [TAG_W-1:0]  fifo_tag  [RSP_DEPTH];
    logic              fifo_err  [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic req_accept, load_accept, store_accept, in_range, rsp_fire, fifo_full;

    assign in_range     = {1'b0, ls2mc_req_addr} < MEM_LIMIT;
    assign req_accept   = ls2mc_req_valid && ls2mc_req_ready;
    assign load_accept  = req_accept && !ls2mc_req_store;
    assign store_accept = req_accept && ls2mc_req_store;
    assign rsp_fire     = mc2ls_rsp_valid && mc2ls_rsp_ready;
    assign fifo_full    = (fifo_cnt == FULL_CREDITS);

    assign ls2mc_req_ready = (credits != '0);
    assign busy            = (credits != FULL_CREDITS);
    assign mc2ls_rsp_valid = (fifo_cnt != '0);
    // Head is gated so the ports read zero while nothing is pending.
    assign mc2ls_rsp_data  = mc2ls_rsp_valid ? fifo_data[rd_ptr] : '0;
    assign mc2ls_rsp_tag   = mc2ls_rsp_valid ? fifo_tag[rd_ptr]  : '0;
    assign mc2ls_rsp_err   = mc2ls_rsp_valid && fifo_err[rd_ptr];

    // Memory is never reset so stores survive a reset_poweron pulse.
    always_ff @(posedge clk) begin
        if (store_accept && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (ls2mc_req_be[i])
                    mem[ls2mc_req_addr][i*8 +: 8] <= ls2mc_req_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_accept) begin
            s1_data <= in_range ? mem[ls2mc_req_addr] : '0;
            s1_tag  <= ls2mc_req_tag;
            s1_err  <= !in_range;
        end
        if (s1_valid) begin
            fifo_data[wr_ptr] <= s1_data;
            fifo_tag[wr_ptr]  <= s1_tag;
            fifo_err[wr_ptr]  <= s1_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            credits   <= FULL_CREDITS;
            s1_valid  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            err_count <= '0;
        end else begin
            s1_valid <= load_accept;
            case ({load_accept, rsp_fire})
                2'b10:   credits <= credits - CNT_W'(1);
                2'b01:   credits <= credits + CNT_W'(1);
                default: credits <= credits;
            endcase
            if (s1_valid)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rsp_fire)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({s1_valid, rsp_fire})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (req_accept && !in_range && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    // Credits reserve a slot for every load, so a push into a full FIFO is a bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset_poweron)
        !(s1_valid && fifo_full && !rsp_fire));

endmodule

// File: tb/tb_ls_mem_cntl_responder.sv
// Directed bench for ls_mem_cntl_responder: hand-computed vectors plus an
// in-order response scoreboard fed by a small reference memory.
module tb_ls_mem_cntl_responder;
    logic        clk = 1'b0;
    logic        reset_poweron;
    logic        ls2mc_req_valid;
    logic        ls2mc_req_ready;
    logic        ls2mc_req_store;
    logic [11:0] ls2mc_req_addr;
    logic [31:0] ls2mc_req_wdata;
    logic [3:0]  ls2mc_req_be;
    logic [3:0]  ls2mc_req_tag;
    logic        mc2ls_rsp_valid;
    logic        mc2ls_rsp_ready;
    logic [31:0] mc2ls_rsp_data;
    logic [3:0]  mc2ls_rsp_tag;
    logic        mc2ls_rsp_err;
    logic        busy;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [36:0] exp_q[$];          // {err, tag, data}
    logic [31:0] ref_mem [4096];

    ls_mem_cntl_responder dut (
        .clk(clk), .reset_poweron(reset_poweron),
        .ls2mc_req_valid(ls2mc_req_valid), .ls2mc_req_ready(ls2mc_req_ready),
        .ls2mc_req_store(ls2mc_req_store), .ls2mc_req_addr(ls2mc_req_addr),
        .ls2mc_req_wdata(ls2mc_req_wdata), .ls2mc_req_be(ls2mc_req_be),
        .ls2mc_req_tag(ls2mc_req_tag),
        .mc2ls_rsp_valid(mc2ls_rsp_valid), .mc2ls_rsp_ready(mc2ls_rsp_ready),
        .mc2ls_rsp_data(mc2ls_rsp_data), .mc2ls_rsp_tag(mc2ls_rsp_tag),
        .mc2ls_rsp_err(mc2ls_rsp_err), .busy(busy), .err_count(err_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // scoreboard: every handshake pops the oldest expected response
    always @(negedge clk) begin
        if (!reset_poweron && mc2ls_rsp_valid && mc2ls_rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_sb", {27'd0, mc2ls_rsp_err, mc2ls_rsp_tag, mc2ls_rsp_data},
                       {27'd0, exp_q.pop_front()});
        end
    end

    // driver: present one request, hold it until accepted, update the model
    task automatic issue(input logic st, input logic [11:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [3:0] tg, input bit rnd);
        bit acc = 1'b0;
        int n = 0;
        ls2mc_req_valid = 1'b1; ls2mc_req_store = st; ls2mc_req_addr = a;
        ls2mc_req_wdata = wd;   ls2mc_req_be = be;    ls2mc_req_tag = tg;
        while (!acc && n < 100) begin
            if (rnd) mc2ls_rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = ls2mc_req_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("req_accept_timeout", 0, 1);
        else if (st) begin
            if (a < 12'd3072)
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_mem[a][i*8 +: 8] = wd[i*8 +: 8];
        end else begin
            exp_q.push_back((a < 12'd3072) ? {1'b0, tg, ref_mem[a]} : {1'b1, tg, 32'd0});
        end
        ls2mc_req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        mc2ls_rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(exp_q.size()), 0);
    endtask

    initial begin
        int acc_n;
        reset_poweron = 1'b1; ls2mc_req_valid = 1'b0; ls2mc_req_store = 1'b0;
        ls2mc_req_addr = '0; ls2mc_req_wdata = '0; ls2mc_req_be = '0;
        ls2mc_req_tag = '0; mc2ls_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_poweron = 1'b0;
        @(negedge clk);
        check("rst_req_ready", ls2mc_req_ready, 1);
        check("rst_rsp_valid", mc2ls_rsp_valid, 0);
        check("rst_rsp_data",  mc2ls_rsp_data, 0);
        check("rst_rsp_tag",   mc2ls_rsp_tag, 0);
        check("rst_rsp_err",   mc2ls_rsp_err, 0);
        check("rst_busy",      busy, 0);
        check("rst_err_count", err_count, 0);
        @(posedge clk); #1;

        // store then load same address, observe latency with rsp_ready low
        issue(1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 4'd0, 1'b0);
        issue(1'b0, 12'h010, 32'd0, 4'b0000, 4'd3, 1'b0);
        @(negedge clk);
        check("lat_gap_valid", mc2ls_rsp_valid, 0);
        check("lat_busy", busy, 1);
        @(negedge clk);
        check("lat_valid", mc2ls_rsp_valid, 1);
        check("lat_data", mc2ls_rsp_data, 32'hDEADBEEF);
        check("lat_tag", mc2ls_rsp_tag, 3);
        check("lat_err", mc2ls_rsp_err, 0);
        @(posedge clk); #1;
        drain("drain_lat");

        // partial byte-enable store
        issue(1'b1, 12'h020, 32'h11223344, 4'b1111, 4'd0, 1'b0);
        issue(1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, 4'd0, 1'b0);
        issue(1'b1, 12'h020, 32'hFFFFFFFF, 4'b0000, 4'd0, 1'b0);
        mc2ls_rsp_ready = 1'b0;
        issue(1'b0, 12'h020, 32'd0, 4'b0000, 4'd9, 1'b0);
        @(negedge clk); @(negedge clk);
        check("be_data", mc2ls_rsp_data, 32'h11BB33DD);
        check("be_err_count", err_count, 0);
        @(posedge clk); #1;
        drain("drain_be");

        // back-pressure: six back-to-back loads with rsp_ready low
        mc2ls_rsp_ready = 1'b0;
        acc_n = 0;
        for (int t = 0; t < 6; t++) begin
            ls2mc_req_valid = 1'b1; ls2mc_req_store = 1'b0; ls2mc_req_tag = 4'(t);
            ls2mc_req_addr = t[0] ? 12'h020 : 12'h010;
            @(negedge clk);
            if (ls2mc_req_ready) begin
                exp_q.push_back({1'b0, 4'(t), t[0] ? 32'h11BB33DD : 32'hDEADBEEF});
                acc_n++;
            end
            @(posedge clk); #1;
        end
        ls2mc_req_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 64'(acc_n), 4);
        check("bp_req_ready", ls2mc_req_ready, 0);
        check("bp_head_tag", mc2ls_rsp_tag, 0);
        @(posedge clk); #1;
        mc2ls_rsp_ready = 1'b1;
        issue(1'b0, 12'h010, 32'd0, 4'b0000, 4'd4, 1'b0);
        issue(1'b0, 12'h020, 32'd0, 4'b0000, 4'd5, 1'b0);
        drain("drain_bp");
        @(negedge clk);
        check("bp_busy_after", busy, 0);
        check("bp_ready_after", ls2mc_req_ready, 1);
        @(posedge clk); #1;

        // out-of-range requests
        mc2ls_rsp_ready = 1'b0;
        issue(1'b0, 12'd3072, 32'd0, 4'b0000, 4'd7, 1'b0);
        issue(1'b1, 12'd4095, 32'h12345678, 4'b1111, 4'd0, 1'b0);
        @(negedge clk);
        check("oor_err", mc2ls_rsp_err, 1);
        check("oor_data", mc2ls_rsp_data, 0);
        check("oor_tag", mc2ls_rsp_tag, 7);
        check("oor_err_count", err_count, 2);
        @(posedge clk); #1;
        drain("drain_oor1");
        mc2ls_rsp_ready = 1'b0;
        issue(1'b0, 12'd4095, 32'd0, 4'b0000, 4'd8, 1'b0);
        @(negedge clk); @(negedge clk);
        check("oor2_err", mc2ls_rsp_err, 1);
        check("oor2_err_count", err_count, 3);
        @(posedge clk); #1;
        drain("drain_oor2");

        // random interleaved traffic over a small preloaded window
        for (int i = 0; i < 8; i++)
            issue(1'b1, 12'h100 + 12'(i), $urandom, 4'b1111, 4'd0, 1'b0);
        for (int i = 0; i < 60; i++)
            issue(1'($urandom_range(0, 1)), 12'h100 + 12'($urandom_range(0, 7)),
                  $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        drain("drain_rand");

        // reset with three loads pending
        mc2ls_rsp_ready = 1'b0;
        issue(1'b0, 12'h010, 32'd0, 4'b0000, 4'd1, 1'b0);
        issue(1'b0, 12'h020, 32'd0, 4'b0000, 4'd2, 1'b0);
        issue(1'b0, 12'h100, 32'd0, 4'b0000, 4'd3, 1'b0);
        reset_poweron = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        reset_poweron = 1'b0;
        @(negedge clk);
        check("mrst_rsp_valid", mc2ls_rsp_valid, 0);
        check("mrst_req_ready", ls2mc_req_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_err_count", err_count, 0);
        @(posedge clk); #1;
        issue(1'b0, 12'h020, 32'd0, 4'b0000, 4'd6, 1'b0);
        @(negedge clk); @(negedge clk);
        check("mrst_keep_data", mc2ls_rsp_data, 32'h11BB33DD);
        check("mrst_keep_tag", mc2ls_rsp_tag, 6);
        @(posedge clk); #1;
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
